mult64_seq: RTL and testbench

MULT64_SEQ -- requirements
Module: mult64_seq

---
 rtl/mult64_seq.sv | 117 +++++++++++
 tb/tb_mult64_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mult64_seq.sv
// Sequential radix-2 shift-add multiplier: WIDTH steps per operation, supports
// unsigned, signed and signed x unsigned operand modes via sign-magnitude.
module mult64_seq #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             flush,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] prod_hi
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] mcand;
    logic [PW-1:0]   acc;
    logic            neg;

    logic            a_signed;
    logic            b_signed;
    logic            neg_c;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]  sum_c;
    logic [PW-1:0]   acc_step;
    logic [PW-1:0]   acc_fix;
    logic            last_step;

    // Operand conditioning: magnitude only for operands treated as signed
    always_comb begin
        a_signed = (op == 2'b01) || (op == 2'b10);
        b_signed = (op == 2'b01);
        a_mag    = (a_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        b_mag    = (b_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
        case (op)
            2'b01:   neg_c = a[WIDTH-1] ^ b[WIDTH-1];
            2'b10:   neg_c = a[WIDTH-1];
            default: neg_c = 1'b0;
        endcase
    end

    // One shift-add step; the extra MSB of sum_c is the carry shifted back in
    always_comb begin
        sum_c     = {1'b0, acc[PW-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : (WIDTH+1)'(0));
        acc_step  = {sum_c, acc[WIDTH-1:1]};
        acc_fix   = neg ? (~acc + PW'(1)) : acc;
        last_step = (cnt == CW'(WIDTH));
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start && !flush) state_nx = RUN;
            RUN: begin
                if (flush)          state_nx = IDLE;
                else if (last_step) state_nx = FIX;
            end
            FIX:  state_nx = flush ? IDLE : DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != IDLE);
            done  <= (state_nx == DONE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            mcand   <= '0;
            acc     <= '0;
            neg     <= 1'b0;
            prod_lo <= '0;
            prod_hi <= '0;
        end else begin
            case (state)
                IDLE: if (start && !flush) begin
                    mcand <= a_mag;
                    acc   <= {WIDTH'(0), b_mag};
                    neg   <= neg_c;
                    cnt   <= '0;
                end
                RUN: if (!flush && !last_step) begin
                    acc <= acc_step;
                    cnt <= cnt + CW'(1);
                end
                FIX: if (!flush) begin
                    prod_hi <= acc_fix[PW-1:WIDTH];
                    prod_lo <= acc_fix[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult64_seq.sv
// Scoreboard bench for mult64_seq: expected products queued at issue, compared on done.
module tb_mult64_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        flush;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy;
    logic        done;
    logic [63:0] prod_lo;
    logic [63:0] prod_hi;

    int errors = 0;
    int checks = 0;
    logic [127:0] sb[$];
    logic [127:0] last_prod = '0;

    mult64_seq #(.WIDTH(64)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .flush(flush), .op(op),
        .a(a), .b(b), .busy(busy), .done(done), .prod_lo(prod_lo), .prod_hi(prod_hi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
        logic signed [127:0] sx;
        logic signed [127:0] sy;
        case (o)
            2'b01: begin sx = {{64{x[63]}}, x}; sy = {{64{y[63]}}, y}; end
            2'b10: begin sx = {{64{x[63]}}, x}; sy = {64'd0, y}; end
            default: begin sx = {64'd0, x}; sy = {64'd0, y}; end
        endcase
        return 128'(sx * sy);
    endfunction

    // Monitor: every done pulse consumes one queued expectation
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 128'd1, 128'd0);
            end else begin
                logic [127:0] e;
                e = sb.pop_front();
                check("prod_hi", {64'd0, prod_hi}, {64'd0, e[127:64]});
                check("prod_lo", {64'd0, prod_lo}, {64'd0, e[63:0]});
                last_prod = e;
            end
        end
    end

    // Drive start for the sampling edge; operands are scrambled right after it
    task automatic launch(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y, input bit push);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        if (push) sb.push_back(model(o, x, y));
        @(posedge clk);
        #1;
        start = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        op = 2'($urandom_range(0, 3));
    endtask

    task automatic run_op(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
        int  n;
        bit  got;
        n = 0;
        got = 0;
        launch(o, x, y, 1'b1);
        while (!got && n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (n == 10) begin
                check("run_busy", {127'd0, busy}, 128'd1);
                check("run_stable", {prod_hi, prod_lo}, last_prod);
            end
            if (done) got = 1;
        end
        check("latency", 128'(n), 128'd66);
        @(posedge clk);
        #1;
        check("done_pulse", {127'd0, done}, 128'd0);
        check("idle_busy", {127'd0, busy}, 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
        #12;
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_done", {127'd0, done}, 128'd0);
        check("rst_prod", {prod_hi, prod_lo}, 128'd0);
        #10 reset_n = 1'b1;

        run_op(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        run_op(2'b01, -64'sd3, 64'd7);
        run_op(2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        run_op(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(2'b11, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
        run_op(2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(2'b01, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001);
        for (int i = 0; i < 5; i++)
            run_op(2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom});

        // Flush mid-RUN with a competing start held high the whole time
        launch(2'b00, 64'd99, 64'd77, 1'b0);
        for (int k = 1; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) begin
                start = 1'b1; a = 64'd3; b = 64'd4;
            end
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush_busy", {127'd0, busy}, 128'd0);
        check("flush_done", {127'd0, done}, 128'd0);
        check("flush_prod", {prod_hi, prod_lo}, last_prod);
        @(posedge clk);
        #1;
        check("flush_prio", {127'd0, busy}, 128'd0);
        start = 1'b0; flush = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        check("flush_nodone", 128'(sb.size()), 128'd0);
        check("flush_keep", {prod_hi, prod_lo}, last_prod);

        // Asynchronous reset in the middle of RUN
        launch(2'b01, 64'd1000, 64'd1000, 1'b0);
        repeat (10) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("arst_busy", {127'd0, busy}, 128'd0);
        check("arst_done", {127'd0, done}, 128'd0);
        check("arst_prod", {prod_hi, prod_lo}, 128'd0);
        #2 reset_n = 1'b1;
        last_prod = '0;
        run_op(2'b00, 64'd5, 64'd6);

        repeat (3) @(posedge clk);
        check("sb_drain", 128'(sb.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
